pico_avalon_bridge: RTL and testbench

- Sits between the PicoRV32 native memory port and the Avalon-MM system interconnect.
- Its master side drives the on-chip program memory's slave port and the other slaves.
- Converts each single-outstanding valid/ready transfer into one Avalon read or write, honouring `waitrequest` and `readdatavalid`.
- Returns read data and `mem_ready` to the core as a one-cycle pulse.

---
 rtl/pico_bridge_pkg.sv | 18 +
 rtl/pico_bridge_watchdog.sv | 29 ++
 rtl/pico_avalon_bridge.sv | 159 +++++++++++++++
 tb/tb_pico_avalon_bridge.sv | 230 +++++++++++++++++++++++
 4 files changed

// File: rtl/pico_bridge_pkg.sv
// Shared types and constants for the PicoRV32 to Avalon-MM bridge.
package pico_bridge_pkg;

    localparam int unsigned ADDR_W = 32;
    localparam int unsigned DATA_W = 32;
    localparam int unsigned STRB_W = 4;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_CMD   = 2'd1,
        ST_RWAIT = 2'd2,
        ST_DONE  = 2'd3
    } state_t;

    localparam logic [DATA_W-1:0] ERR_RDATA_DEFAULT = 32'hDEAD_BEEF;
    localparam logic [STRB_W-1:0] BYTEEN_ALL        = 4'hF;

endpackage

// File: rtl/pico_bridge_watchdog.sv
// Transfer watchdog: counts active bridge cycles and flags expiry at TIMEOUT_CYCLES-1.
module pico_bridge_watchdog #(
    parameter int unsigned TIMEOUT_CYCLES = 1024
) (
    input  logic clk,
    input  logic resetn,
    input  logic clear,
    input  logic enable,
    output logic expired_c
);

    localparam int unsigned CNT_W = $clog2(TIMEOUT_CYCLES);

    logic [CNT_W-1:0] count;

    // Saturates at the limit so a stalled handshake cannot wrap the counter.
    always_ff @(posedge clk) begin
        if (!resetn) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && !expired_c) begin
            count <= count + CNT_W'(1);
        end
    end

    assign expired_c = enable && (count == CNT_W'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/pico_avalon_bridge.sv
// PicoRV32 native memory port to Avalon-MM master, one transfer outstanding.
// Define PICO_AVALON_BRIDGE_TIMEOUT_EN to enable the transfer watchdog and bus_error.
module pico_avalon_bridge
    import pico_bridge_pkg::*;
#(
    parameter int unsigned       TIMEOUT_CYCLES = 1024,
    parameter logic [DATA_W-1:0] ERR_RDATA      = ERR_RDATA_DEFAULT
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              mem_valid,
    input  logic              mem_instr,
    input  logic [ADDR_W-1:0] mem_addr,
    input  logic [DATA_W-1:0] mem_wdata,
    input  logic [STRB_W-1:0] mem_wstrb,
    output logic              mem_ready,
    output logic [DATA_W-1:0] mem_rdata,
    output logic [ADDR_W-1:0] avm_address,
    output logic [STRB_W-1:0] avm_byteenable,
    output logic              avm_read,
    output logic              avm_write,
    output logic [DATA_W-1:0] avm_writedata,
    input  logic              avm_waitrequest,
    input  logic [DATA_W-1:0] avm_readdata,
    input  logic              avm_readdatavalid,
    output logic              bus_error
);

    state_t            state, state_next;
    logic              after_done;
    logic              timeout;
    logic [ADDR_W-1:0] address_next;
    logic [STRB_W-1:0] byteenable_next;
    logic              read_next, write_next;
    logic [DATA_W-1:0] writedata_next;
    logic              ready_next;
    logic [DATA_W-1:0] rdata_next;
    logic              error_next;

    // Fetch flag and sub-word address bits carry no meaning on a word-wide bus.
    logic unused_ok;
    assign unused_ok = ^{mem_instr, mem_addr[1:0]};

`ifdef PICO_AVALON_BRIDGE_TIMEOUT_EN
    pico_bridge_watchdog #(
        .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
    ) u_watchdog (
        .clk      (clk),
        .resetn   (resetn),
        .clear    (state == ST_IDLE),
        .enable   ((state == ST_CMD) || (state == ST_RWAIT)),
        .expired_c(timeout)
    );
`else
    localparam int unsigned unused_timeout_cycles = TIMEOUT_CYCLES;
    assign timeout = 1'b0;
`endif

    always_ff @(posedge clk) begin
        if (!resetn) begin
            state          <= ST_IDLE;
            after_done     <= 1'b0;
            avm_address    <= '0;
            avm_byteenable <= '0;
            avm_read       <= 1'b0;
            avm_write      <= 1'b0;
            avm_writedata  <= '0;
            mem_ready      <= 1'b0;
            mem_rdata      <= '0;
            bus_error      <= 1'b0;
        end else begin
            state          <= state_next;
            after_done     <= (state == ST_DONE);
            avm_address    <= address_next;
            avm_byteenable <= byteenable_next;
            avm_read       <= read_next;
            avm_write      <= write_next;
            avm_writedata  <= writedata_next;
            mem_ready      <= ready_next;
            mem_rdata      <= rdata_next;
            bus_error      <= error_next;
        end
    end

    // Next state and next value of every registered output.
    always_comb begin
        state_next      = state;
        address_next    = avm_address;
        byteenable_next = avm_byteenable;
        read_next       = avm_read;
        write_next      = avm_write;
        writedata_next  = avm_writedata;
        ready_next      = 1'b0;
        rdata_next      = mem_rdata;
        error_next      = 1'b0;

        case (state)
            ST_IDLE: begin
                // The core still holds mem_valid in the cycle right after completion.
                if (mem_valid && !after_done) begin
                    address_next   = {mem_addr[ADDR_W-1:2], 2'b00};
                    writedata_next = mem_wdata;
                    if (mem_wstrb == STRB_W'(0)) begin
                        read_next       = 1'b1;
                        byteenable_next = BYTEEN_ALL;
                    end else begin
                        write_next      = 1'b1;
                        byteenable_next = mem_wstrb;
                    end
                    state_next = ST_CMD;
                end
            end
            ST_CMD: begin
                if (!avm_waitrequest) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    if (avm_write) begin
                        ready_next = 1'b1;
                        state_next = ST_DONE;
                    end else if (avm_readdatavalid) begin
                        rdata_next = avm_readdata;
                        ready_next = 1'b1;
                        state_next = ST_DONE;
                    end else begin
                        state_next = ST_RWAIT;
                    end
                end else if (timeout) begin
                    read_next  = 1'b0;
                    write_next = 1'b0;
                    ready_next = 1'b1;
                    error_next = 1'b1;
                    if (avm_read) begin
                        rdata_next = ERR_RDATA;
                    end
                    state_next = ST_DONE;
                end
            end
            ST_RWAIT: begin
                if (avm_readdatavalid) begin
                    rdata_next = avm_readdata;
                    ready_next = 1'b1;
                    state_next = ST_DONE;
                end else if (timeout) begin
                    rdata_next = ERR_RDATA;
                    ready_next = 1'b1;
                    error_next = 1'b1;
                    state_next = ST_DONE;
                end
            end
            ST_DONE: begin
                state_next = ST_IDLE;
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_pico_avalon_bridge.sv
// Directed scoreboard bench for pico_avalon_bridge (watchdog case under PICO_AVALON_BRIDGE_TIMEOUT_EN).
module tb_pico_avalon_bridge;

    logic        clk = 1'b0;
    logic        resetn;
    logic        mem_valid, mem_instr;
    logic [31:0] mem_addr, mem_wdata;
    logic [3:0]  mem_wstrb;
    logic        mem_ready;
    logic [31:0] mem_rdata;
    logic [31:0] avm_address;
    logic [3:0]  avm_byteenable;
    logic        avm_read, avm_write;
    logic [31:0] avm_writedata;
    logic        avm_waitrequest;
    logic [31:0] avm_readdata;
    logic        avm_readdatavalid;
    logic        bus_error;

    pico_avalon_bridge #(
        .TIMEOUT_CYCLES(8),
        .ERR_RDATA     (32'hDEAD_BEEF)
    ) dut (
        .clk              (clk),
        .resetn           (resetn),
        .mem_valid        (mem_valid),
        .mem_instr        (mem_instr),
        .mem_addr         (mem_addr),
        .mem_wdata        (mem_wdata),
        .mem_wstrb        (mem_wstrb),
        .mem_ready        (mem_ready),
        .mem_rdata        (mem_rdata),
        .avm_address      (avm_address),
        .avm_byteenable   (avm_byteenable),
        .avm_read         (avm_read),
        .avm_write        (avm_write),
        .avm_writedata    (avm_writedata),
        .avm_waitrequest  (avm_waitrequest),
        .avm_readdata     (avm_readdata),
        .avm_readdatavalid(avm_readdatavalid),
        .bus_error        (bus_error)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic [31:0] rdata;
        logic        rd;
        logic        err;
    } exp_t;

    exp_t sb_q[$];
    int   total = 0;
    int   bad   = 0;
    int   acc_count = 0;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h at %0t", name, act, exp, $time);
        end
    endtask

    // Avalon commands actually accepted by the slave.
    always @(posedge clk) begin
        if (resetn && (avm_read || avm_write) && !avm_waitrequest) begin
            acc_count <= acc_count + 1;
        end
    end

    // Monitor: every mem_ready pulse consumes one expected completion.
    always @(negedge clk) begin
        exp_t e;
        if (resetn && mem_ready) begin
            if (sb_q.size() == 0) begin
                total++;
                bad++;
                $display("FAIL unexpected_ready: got 1 want 0 at %0t", $time);
            end else begin
                e = sb_q.pop_front();
                if (e.rd) chk("mem_rdata", mem_rdata, e.rdata);
                chk("bus_error", 32'(bus_error), 32'(e.err));
            end
        end
    end

    task automatic xfer(input logic [31:0] addr, input logic [31:0] exp_addr,
                        input logic [31:0] wdata, input logic [3:0] wstrb,
                        input int nwait, input int lat, input logic [31:0] rdata,
                        input bit b2b, input int exp_ready, input bit exp_err,
                        input int exp_acc);
        int   d, kk, cmd_end, acc0;
        bit   seen, is_rd;
        logic [3:0] be;
        exp_t e;
        is_rd   = (wstrb == 4'd0);
        be      = is_rd ? 4'hF : wstrb;
        d       = b2b ? 1 : 0;
        cmd_end = (nwait + 1 < exp_ready - 1) ? nwait + 1 : exp_ready - 1;
        if (!b2b) begin
            @(posedge clk); #1;
            mem_valid = 1'b0;
        end
        e.rdata = rdata;
        e.rd    = is_rd;
        e.err   = exp_err;
        sb_q.push_back(e);
        acc0 = acc_count;
        seen = 1'b0;
        for (int k = 0; k < 300 && !seen; k++) begin
            @(posedge clk); #1;
            if (k == 0) begin
                mem_valid = 1'b1;
                mem_instr = is_rd;
                mem_addr  = addr;
                mem_wdata = wdata;
                mem_wstrb = wstrb;
            end
            kk = k - d;
            avm_waitrequest   = (kk >= 1) && (kk <= nwait);
            avm_readdatavalid = is_rd && (kk == nwait + 1 + lat);
            avm_readdata      = avm_readdatavalid ? rdata : 32'h0BAD_0BAD;
            @(negedge clk);
            if (kk >= 1 && kk <= cmd_end) begin
                chk("avm_read", 32'(avm_read), 32'(is_rd));
                chk("avm_write", 32'(avm_write), 32'(!is_rd));
                chk("avm_address", avm_address, exp_addr);
                chk("avm_byteenable", 32'(avm_byteenable), 32'(be));
                if (!is_rd) chk("avm_writedata", avm_writedata, wdata);
            end else begin
                chk("no_cmd", 32'(avm_read || avm_write), 32'd0);
            end
            if (mem_ready) begin
                seen = 1'b1;
                chk("ready_cycle", 32'(kk), 32'(exp_ready));
            end
        end
        if (!seen) begin
            total++;
            bad++;
            $display("FAIL ready_timeout: got none want cycle %0d", exp_ready);
        end
        chk("accepts", 32'(acc_count - acc0), 32'(exp_acc));
    endtask

    initial begin
        resetn            = 1'b0;
        mem_valid         = 1'b0;
        mem_instr         = 1'b0;
        mem_addr          = '0;
        mem_wdata         = '0;
        mem_wstrb         = '0;
        avm_waitrequest   = 1'b0;
        avm_readdata      = '0;
        avm_readdatavalid = 1'b0;
        repeat (3) @(posedge clk);
        #1 resetn = 1'b1;
        @(negedge clk);
        chk("rst_mem_ready", 32'(mem_ready), 32'd0);
        chk("rst_mem_rdata", mem_rdata, 32'd0);
        chk("rst_cmd", 32'({avm_read, avm_write, bus_error}), 32'd0);
        chk("rst_address", avm_address, 32'd0);

        // zero-wait read, 1-cycle latency
        xfer(32'h0000_0010, 32'h0000_0010, 32'h0, 4'b0000, 0, 1, 32'h1234_5678, 1'b0, 3, 1'b0, 1);
        // write with three stall cycles, unaligned address
        xfer(32'h0000_0022, 32'h0000_0020, 32'hCAFE_F00D, 4'b0011, 3, 0, 32'h0, 1'b0, 5, 1'b0, 1);
        // readdatavalid together with waitrequest falling
        xfer(32'h0000_0104, 32'h0000_0104, 32'h0, 4'b0000, 2, 0, 32'hA5A5_0F0F, 1'b0, 4, 1'b0, 1);
        // long read latency
        xfer(32'h8000_0203, 32'h8000_0200, 32'h0, 4'b0000, 1, 3, 32'h0F1E_2D3C, 1'b0, 6, 1'b0, 1);

        // reset during RWAIT, then a late response that must be dropped
        @(posedge clk); #1 mem_valid = 1'b0;
        for (int k = 0; k <= 8; k++) begin
            @(posedge clk); #1;
            avm_waitrequest   = 1'b0;
            avm_readdatavalid = (k == 5);
            avm_readdata      = (k == 5) ? 32'h5555_AAAA : 32'h0BAD_0BAD;
            if (k == 0) begin
                mem_valid = 1'b1;
                mem_addr  = 32'h0000_0040;
                mem_wstrb = 4'b0000;
            end
            if (k == 3) begin
                resetn    = 1'b0;
                mem_valid = 1'b0;
            end
            if (k == 4) resetn = 1'b1;
            @(negedge clk);
            if (k == 4) begin
                chk("arst_cmd", 32'({avm_read, avm_write, bus_error}), 32'd0);
                chk("arst_address", avm_address, 32'd0);
                chk("arst_byteenable", 32'(avm_byteenable), 32'd0);
                chk("arst_writedata", avm_writedata, 32'd0);
                chk("arst_mem_rdata", mem_rdata, 32'd0);
            end
            if (k >= 4) chk("arst_no_ready", 32'(mem_ready), 32'd0);
        end
        xfer(32'h0000_0044, 32'h0000_0044, 32'h0, 4'b0000, 0, 1, 32'h7777_1111, 1'b0, 3, 1'b0, 1);

        // back-to-back fetch, store, fetch
        xfer(32'h0000_0100, 32'h0000_0100, 32'h0, 4'b0000, 0, 1, 32'h0000_0013, 1'b0, 3, 1'b0, 1);
        xfer(32'h0000_0200, 32'h0000_0200, 32'h1357_9BDF, 4'b1100, 1, 0, 32'h0, 1'b1, 3, 1'b0, 1);
        xfer(32'h0000_0104, 32'h0000_0104, 32'h0, 4'b0000, 0, 2, 32'h0000_0093, 1'b1, 4, 1'b0, 1);

`ifdef PICO_AVALON_BRIDGE_TIMEOUT_EN
        // waitrequest stuck high: watchdog expires with TIMEOUT_CYCLES=8
        xfer(32'h0000_0300, 32'h0000_0300, 32'h0, 4'b0000, 1000, 0, 32'hDEAD_BEEF, 1'b0, 9, 1'b1, 0);
        xfer(32'h0000_0304, 32'h0000_0304, 32'h2468_ACE0, 4'b1111, 1000, 0, 32'h0, 1'b0, 9, 1'b1, 0);
        xfer(32'h0000_0308, 32'h0000_0308, 32'h0, 4'b0000, 0, 1, 32'h600D_600D, 1'b0, 3, 1'b0, 1);
`endif

        @(posedge clk); #1;
        mem_valid       = 1'b0;
        avm_waitrequest = 1'b0;
        repeat (4) @(negedge clk);
        chk("scoreboard_empty", 32'(sb_q.size()), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL global_timeout: simulation did not finish");
        $fatal(1);
    end

endmodule
